// File: rtl/axil_skid_slice.sv
// AXI4-Lite register slice: one two-entry skid stage per channel (AW, W, B, AR, R),
// each optionally replaced by a wire so individual channels can be left combinational.

module axil_skid_stage #(
    parameter int WIDTH  = 8,
    parameter bit BYPASS = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_payload,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_payload
);

    generate
        if (BYPASS) begin : g_bypass
            assign out_valid   = in_valid;
            assign out_payload = in_payload;
            assign in_ready    = out_ready;
        end else begin : g_skid
            logic             out_valid_r;
            logic             skid_valid_r;
            logic             in_ready_r;
            logic [WIDTH-1:0] out_payload_r;
            logic [WIDTH-1:0] skid_payload_r;

            logic             in_fire_s;
            logic             out_fire_s;
            logic             out_valid_s;
            logic             skid_valid_s;
            logic [WIDTH-1:0] out_payload_s;
            logic [WIDTH-1:0] skid_payload_s;

            // Next-state of the out/skid pair; the out slot refills from skid before the input.
            always_comb begin
                in_fire_s      = in_valid & in_ready_r;
                out_fire_s     = out_valid_r & out_ready;
                out_valid_s    = out_valid_r;
                out_payload_s  = out_payload_r;
                skid_valid_s   = skid_valid_r;
                skid_payload_s = skid_payload_r;
                if (!out_valid_r || out_fire_s) begin
                    if (skid_valid_r) begin
                        out_valid_s   = 1'b1;
                        out_payload_s = skid_payload_r;
                        skid_valid_s  = 1'b0;
                    end else if (in_fire_s) begin
                        out_valid_s   = 1'b1;
                        out_payload_s = in_payload;
                    end else begin
                        out_valid_s   = 1'b0;
                    end
                end else if (in_fire_s) begin
                    skid_valid_s   = 1'b1;
                    skid_payload_s = in_payload;
                end else begin
                    skid_valid_s   = skid_valid_r;
                end
            end

            // State registers; ready is precomputed so no input reaches an output combinationally.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    out_valid_r    <= 1'b0;
                    skid_valid_r   <= 1'b0;
                    in_ready_r     <= 1'b1;
                    out_payload_r  <= {WIDTH{1'b0}};
                    skid_payload_r <= {WIDTH{1'b0}};
                end else begin
                    out_valid_r    <= out_valid_s;
                    skid_valid_r   <= skid_valid_s;
                    in_ready_r     <= ~skid_valid_s;
                    out_payload_r  <= out_payload_s;
                    skid_payload_r <= skid_payload_s;
                end
            end

            assign out_valid   = out_valid_r;
            assign out_payload = out_payload_r;
            assign in_ready    = in_ready_r;
        end
    endgenerate

endmodule

module axil_skid_slice #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter bit BYPASS_AW  = 1'b0,
    parameter bit BYPASS_W   = 1'b0,
    parameter bit BYPASS_B   = 1'b0,
    parameter bit BYPASS_AR  = 1'b0,
    parameter bit BYPASS_R   = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    // upstream (slave modport)
    input  logic [ADDR_WIDTH-1:0] slv_aw_addr,
    input  logic [2:0]            slv_aw_prot,
    input  logic                  slv_aw_valid,
    output logic                  slv_aw_ready,
    input  logic [DATA_WIDTH-1:0] slv_w_data,
    input  logic [STRB_WIDTH-1:0] slv_w_strb,
    input  logic                  slv_w_valid,
    output logic                  slv_w_ready,
    output logic [1:0]            slv_b_resp,
    output logic                  slv_b_valid,
    input  logic                  slv_b_ready,
    input  logic [ADDR_WIDTH-1:0] slv_ar_addr,
    input  logic [2:0]            slv_ar_prot,
    input  logic                  slv_ar_valid,
    output logic                  slv_ar_ready,
    output logic [DATA_WIDTH-1:0] slv_r_data,
    output logic [1:0]            slv_r_resp,
    output logic                  slv_r_valid,
    input  logic                  slv_r_ready,
    // downstream (master modport)
    output logic [ADDR_WIDTH-1:0] mst_aw_addr,
    output logic [2:0]            mst_aw_prot,
    output logic                  mst_aw_valid,
    input  logic                  mst_aw_ready,
    output logic [DATA_WIDTH-1:0] mst_w_data,
    output logic [STRB_WIDTH-1:0] mst_w_strb,
    output logic                  mst_w_valid,
    input  logic                  mst_w_ready,
    input  logic [1:0]            mst_b_resp,
    input  logic                  mst_b_valid,
    output logic                  mst_b_ready,
    output logic [ADDR_WIDTH-1:0] mst_ar_addr,
    output logic [2:0]            mst_ar_prot,
    output logic                  mst_ar_valid,
    input  logic                  mst_ar_ready,
    input  logic [DATA_WIDTH-1:0] mst_r_data,
    input  logic [1:0]            mst_r_resp,
    input  logic                  mst_r_valid,
    output logic                  mst_r_ready
);

    localparam int AX_W = ADDR_WIDTH + 3;
    localparam int W_W  = DATA_WIDTH + STRB_WIDTH;
    localparam int B_W  = 2;
    localparam int R_W  = DATA_WIDTH + 2;

    logic [AX_W-1:0] aw_out_s;
    logic [W_W-1:0]  w_out_s;
    logic [B_W-1:0]  b_out_s;
    logic [AX_W-1:0] ar_out_s;
    logic [R_W-1:0]  r_out_s;

    // Request channels flow slv -> mst, response channels mst -> slv.
    axil_skid_stage #(.WIDTH(AX_W), .BYPASS(BYPASS_AW)) u_aw (
        .clk(clk), .rst(rst),
        .in_valid(slv_aw_valid), .in_ready(slv_aw_ready),
        .in_payload({slv_aw_addr, slv_aw_prot}),
        .out_valid(mst_aw_valid), .out_ready(mst_aw_ready), .out_payload(aw_out_s)
    );

    axil_skid_stage #(.WIDTH(W_W), .BYPASS(BYPASS_W)) u_w (
        .clk(clk), .rst(rst),
        .in_valid(slv_w_valid), .in_ready(slv_w_ready),
        .in_payload({slv_w_data, slv_w_strb}),
        .out_valid(mst_w_valid), .out_ready(mst_w_ready), .out_payload(w_out_s)
    );

    axil_skid_stage #(.WIDTH(B_W), .BYPASS(BYPASS_B)) u_b (
        .clk(clk), .rst(rst),
        .in_valid(mst_b_valid), .in_ready(mst_b_ready),
        .in_payload(mst_b_resp),
        .out_valid(slv_b_valid), .out_ready(slv_b_ready), .out_payload(b_out_s)
    );

    axil_skid_stage #(.WIDTH(AX_W), .BYPASS(BYPASS_AR)) u_ar (
        .clk(clk), .rst(rst),
        .in_valid(slv_ar_valid), .in_ready(slv_ar_ready),
        .in_payload({slv_ar_addr, slv_ar_prot}),
        .out_valid(mst_ar_valid), .out_ready(mst_ar_ready), .out_payload(ar_out_s)
    );

    axil_skid_stage #(.WIDTH(R_W), .BYPASS(BYPASS_R)) u_r (
        .clk(clk), .rst(rst),
        .in_valid(mst_r_valid), .in_ready(mst_r_ready),
        .in_payload({mst_r_data, mst_r_resp}),
        .out_valid(slv_r_valid), .out_ready(slv_r_ready), .out_payload(r_out_s)
    );

    assign {mst_aw_addr, mst_aw_prot} = aw_out_s;
    assign {mst_w_data, mst_w_strb}   = w_out_s;
    assign slv_b_resp                 = b_out_s;
    assign {mst_ar_addr, mst_ar_prot} = ar_out_s;
    assign {slv_r_data, slv_r_resp}   = r_out_s;

endmodule

// File: tb/tb_axil_skid_slice.sv
// Self-checking bench for axil_skid_slice: directed channel scenarios plus a randomized
// all-channel run checked against a per-channel FIFO model (capacity 2, latency 1).

module tb_axil_skid_slice;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] slv_aw_addr = 32'd0, slv_ar_addr = 32'd0, slv_w_data = 32'd0;
    logic [2:0]  slv_aw_prot = 3'd0, slv_ar_prot = 3'd0;
    logic [3:0]  slv_w_strb = 4'd0;
    logic        slv_aw_valid = 1'b0, slv_w_valid = 1'b0, slv_ar_valid = 1'b0;
    logic        slv_b_ready = 1'b0, slv_r_ready = 1'b0;
    logic        slv_aw_ready, slv_w_ready, slv_ar_ready, slv_b_valid, slv_r_valid;
    logic [1:0]  slv_b_resp, slv_r_resp;
    logic [31:0] slv_r_data;
    logic [31:0] mst_aw_addr, mst_ar_addr, mst_w_data;
    logic [2:0]  mst_aw_prot, mst_ar_prot;
    logic [3:0]  mst_w_strb;
    logic        mst_aw_valid, mst_w_valid, mst_ar_valid, mst_b_ready, mst_r_ready;
    logic        mst_aw_ready = 1'b0, mst_w_ready = 1'b0, mst_ar_ready = 1'b0;
    logic        mst_b_valid = 1'b0, mst_r_valid = 1'b0;
    logic [1:0]  mst_b_resp = 2'd0, mst_r_resp = 2'd0;
    logic [31:0] mst_r_data = 32'd0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    axil_skid_slice dut (
        .clk(clk), .rst(rst),
        .slv_aw_addr(slv_aw_addr), .slv_aw_prot(slv_aw_prot), .slv_aw_valid(slv_aw_valid), .slv_aw_ready(slv_aw_ready),
        .slv_w_data(slv_w_data), .slv_w_strb(slv_w_strb), .slv_w_valid(slv_w_valid), .slv_w_ready(slv_w_ready),
        .slv_b_resp(slv_b_resp), .slv_b_valid(slv_b_valid), .slv_b_ready(slv_b_ready),
        .slv_ar_addr(slv_ar_addr), .slv_ar_prot(slv_ar_prot), .slv_ar_valid(slv_ar_valid), .slv_ar_ready(slv_ar_ready),
        .slv_r_data(slv_r_data), .slv_r_resp(slv_r_resp), .slv_r_valid(slv_r_valid), .slv_r_ready(slv_r_ready),
        .mst_aw_addr(mst_aw_addr), .mst_aw_prot(mst_aw_prot), .mst_aw_valid(mst_aw_valid), .mst_aw_ready(mst_aw_ready),
        .mst_w_data(mst_w_data), .mst_w_strb(mst_w_strb), .mst_w_valid(mst_w_valid), .mst_w_ready(mst_w_ready),
        .mst_b_resp(mst_b_resp), .mst_b_valid(mst_b_valid), .mst_b_ready(mst_b_ready),
        .mst_ar_addr(mst_ar_addr), .mst_ar_prot(mst_ar_prot), .mst_ar_valid(mst_ar_valid), .mst_ar_ready(mst_ar_ready),
        .mst_r_data(mst_r_data), .mst_r_resp(mst_r_resp), .mst_r_valid(mst_r_valid), .mst_r_ready(mst_r_ready)
    );

    // Channel index: 0 AW, 1 W, 2 B, 3 AR, 4 R. "up" is the producer side, "dn" the consumer side.
    function automatic int pw(input int c);
        case (c)
            0, 3:    return 35;
            1:       return 36;
            2:       return 2;
            default: return 34;
        endcase
    endfunction

    function automatic logic [63:0] rnd(input int c);
        logic [63:0] m;
        m = (64'd1 << pw(c)) - 64'd1;
        return {$urandom, $urandom} & m;
    endfunction

    task automatic set_up(input int c, input logic v, input logic [63:0] p);
        case (c)
            0: begin slv_aw_valid = v; slv_aw_addr = p[34:3]; slv_aw_prot = p[2:0]; end
            1: begin slv_w_valid = v; slv_w_data = p[35:4]; slv_w_strb = p[3:0]; end
            2: begin mst_b_valid = v; mst_b_resp = p[1:0]; end
            3: begin slv_ar_valid = v; slv_ar_addr = p[34:3]; slv_ar_prot = p[2:0]; end
            default: begin mst_r_valid = v; mst_r_data = p[33:2]; mst_r_resp = p[1:0]; end
        endcase
    endtask

    task automatic set_dn_r(input int c, input logic r);
        case (c)
            0: mst_aw_ready = r;
            1: mst_w_ready = r;
            2: slv_b_ready = r;
            3: mst_ar_ready = r;
            default: slv_r_ready = r;
        endcase
    endtask

    function automatic logic up_r(input int c);
        case (c)
            0: return slv_aw_ready;
            1: return slv_w_ready;
            2: return mst_b_ready;
            3: return slv_ar_ready;
            default: return mst_r_ready;
        endcase
    endfunction

    function automatic logic dn_v(input int c);
        case (c)
            0: return mst_aw_valid;
            1: return mst_w_valid;
            2: return slv_b_valid;
            3: return mst_ar_valid;
            default: return slv_r_valid;
        endcase
    endfunction

    function automatic logic [63:0] dn_pl(input int c);
        case (c)
            0: return {29'd0, mst_aw_addr, mst_aw_prot};
            1: return {28'd0, mst_w_data, mst_w_strb};
            2: return {62'd0, slv_b_resp};
            3: return {29'd0, mst_ar_addr, mst_ar_prot};
            default: return {30'd0, slv_r_data, slv_r_resp};
        endcase
    endfunction

    task automatic idle_all();
        for (int c = 0; c < 5; c++) begin
            set_up(c, 1'b0, 64'd0);
            set_dn_r(c, 1'b1);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (dn_v(c) !== 1'b0) begin failures++; $display("FAIL reset_valid ch%0d: got %b expected 0", c, dn_v(c)); end
            checks++;
            if (up_r(c) !== 1'b1) begin failures++; $display("FAIL reset_ready ch%0d: got %b expected 1", c, up_r(c)); end
        end
        rst = 1'b0;
        idle_all();
    endtask

    task automatic test_basic();
        logic [63:0] p;
        for (int c = 0; c < 5; c++) begin
            case (c)
                0, 3:    p = {29'd0, $urandom, 3'd0};
                1:       p = {28'd0, $urandom, 4'hF};
                2:       p = 64'd0;
                default: p = {30'd0, $urandom, 2'd0};
            endcase
            @(negedge clk);
            set_dn_r(c, 1'b1);
            set_up(c, 1'b1, p);
            @(negedge clk);
            set_up(c, 1'b0, 64'd0);
            checks++;
            if (dn_v(c) !== 1'b1) begin failures++; $display("FAIL basic_valid ch%0d: got %b expected 1", c, dn_v(c)); end
            checks++;
            if (dn_pl(c) !== p) begin failures++; $display("FAIL basic_payload ch%0d: got %h expected %h", c, dn_pl(c), p); end
            @(negedge clk);
            checks++;
            if (dn_v(c) !== 1'b0) begin failures++; $display("FAIL basic_drain ch%0d: got %b expected 0", c, dn_v(c)); end
        end
    endtask

    task automatic test_stall(input int c);
        logic [63:0] q[$];
        logic [63:0] p;
        int acc;
        acc = 0;
        p = rnd(c);
        @(negedge clk);
        set_dn_r(c, 1'b0);
        for (int i = 0; i < 5; i++) begin
            set_up(c, 1'b1, p);
            checks++;
            if (up_r(c) !== (q.size() < 2)) begin
                failures++; $display("FAIL stall_ready ch%0d cyc%0d: got %b expected %b", c, i, up_r(c), q.size() < 2);
            end
            if (up_r(c)) begin
                q.push_back(p);
                acc++;
                p = rnd(c);
            end
            @(negedge clk);
        end
        checks++;
        if (acc !== 2) begin failures++; $display("FAIL stall_accepted ch%0d: got %0d expected 2", c, acc); end
        set_up(c, 1'b0, 64'd0);
        set_dn_r(c, 1'b1);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (dn_v(c) !== (q.size() > 0)) begin
                failures++; $display("FAIL drain_valid ch%0d cyc%0d: got %b expected %b", c, i, dn_v(c), q.size() > 0);
            end
            checks++;
            if (up_r(c) !== (q.size() < 2)) begin
                failures++; $display("FAIL drain_ready ch%0d cyc%0d: got %b expected %b", c, i, up_r(c), q.size() < 2);
            end
            if (dn_v(c) && q.size() > 0) begin
                checks++;
                if (dn_pl(c) !== q[0]) begin
                    failures++; $display("FAIL drain_order ch%0d cyc%0d: got %h expected %h", c, i, dn_pl(c), q[0]);
                end
                void'(q.pop_front());
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] sent[16];
        @(negedge clk);
        set_dn_r(0, 1'b1);
        for (int i = 0; i <= 16; i++) begin
            if (i > 0) begin
                checks++;
                if (dn_v(0) !== 1'b1 || dn_pl(0) !== sent[i-1]) begin
                    failures++; $display("FAIL b2b_beat %0d: got v=%b %h expected v=1 %h", i - 1, dn_v(0), dn_pl(0), sent[i-1]);
                end
            end
            checks++;
            if (up_r(0) !== 1'b1) begin failures++; $display("FAIL b2b_ready cyc%0d: got %b expected 1", i, up_r(0)); end
            if (i < 16) begin
                sent[i] = rnd(0);
                set_up(0, 1'b1, sent[i]);
            end else begin
                set_up(0, 1'b0, 64'd0);
            end
            @(negedge clk);
        end
        checks++;
        if (dn_v(0) !== 1'b0) begin failures++; $display("FAIL b2b_end: got %b expected 0", dn_v(0)); end
    endtask

    task automatic test_random();
        logic [63:0] mq[5][$];
        logic [63:0] up_p[5];
        logic        pend[5];
        logic        uv, dr;
        for (int c = 0; c < 5; c++) pend[c] = 1'b0;
        @(negedge clk);
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int c = 0; c < 5; c++) begin
                checks++;
                if (dn_v(c) !== (mq[c].size() > 0)) begin
                    failures++; $display("FAIL rnd_valid ch%0d cyc%0d: got %b expected %b", c, cyc, dn_v(c), mq[c].size() > 0);
                end
                checks++;
                if (up_r(c) !== (mq[c].size() < 2)) begin
                    failures++; $display("FAIL rnd_ready ch%0d cyc%0d: got %b expected %b", c, cyc, up_r(c), mq[c].size() < 2);
                end
                if (mq[c].size() > 0) begin
                    checks++;
                    if (dn_pl(c) !== mq[c][0]) begin
                        failures++; $display("FAIL rnd_payload ch%0d cyc%0d: got %h expected %h", c, cyc, dn_pl(c), mq[c][0]);
                    end
                end
                if (pend[c]) begin
                    uv = 1'b1;
                end else begin
                    uv = ($urandom_range(0, 3) != 0);
                    up_p[c] = rnd(c);
                end
                dr = ($urandom_range(0, 2) != 0);
                set_up(c, uv, up_p[c]);
                set_dn_r(c, dr);
                if (dn_v(c) && dr && mq[c].size() > 0) void'(mq[c].pop_front());
                if (uv && up_r(c)) begin
                    mq[c].push_back(up_p[c]);
                    pend[c] = 1'b0;
                end else begin
                    pend[c] = uv;
                end
            end
            @(negedge clk);
        end
        idle_all();
    endtask

    task automatic test_reset_mid_stall();
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            for (int c = 0; c < 5; c++) begin
                set_dn_r(c, 1'b0);
                set_up(c, 1'b1, rnd(c));
            end
            @(negedge clk);
        end
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (up_r(c) !== 1'b0) begin failures++; $display("FAIL prestall_ready ch%0d: got %b expected 0", c, up_r(c)); end
        end
        rst = 1'b1;
        #1;
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (dn_v(c) !== 1'b0) begin failures++; $display("FAIL rst_valid ch%0d: got %b expected 0", c, dn_v(c)); end
            checks++;
            if (up_r(c) !== 1'b1) begin failures++; $display("FAIL rst_ready ch%0d: got %b expected 1", c, up_r(c)); end
            set_up(c, 1'b0, 64'd0);
            set_dn_r(c, 1'b1);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            for (int c = 0; c < 5; c++) begin
                checks++;
                if (dn_v(c) !== 1'b0) begin failures++; $display("FAIL post_rst_stale ch%0d cyc%0d: got %b expected 0", c, i, dn_v(c)); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        for (int c = 0; c < 5; c++) test_stall(c);
        idle_all();
        test_back_to_back();
        test_random();
        test_reset_mid_stall();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
